mac_frame_serializer: RTL and testbench
=======================================

Name: mac_frame_serializer

Overview:
- Sits between the Data Link Layer MAC frame interface and the multi-lane controller in the TX path of the physical layer top.
- Buffers 32-bit MAC frames in a small frame FIFO and unpacks them into a byte stream, least significant byte first, under valid/ready handshake on both sides.
- Marks start and end of packet on the byte stream for downstream framing and lane striping.

Parameters:
- MAC_FRAME_WIDTH, 32: input frame width; multiple of 8; BYTES_PER_FRAME = MAC_FRAME_WIDTH/8.
- FIFO_DEPTH, 4: frame FIFO entries; power of 2, >= 2.

Ports:
- clk_i  input  1  sole clock.
- rst_i  input  1  synchronous, active-low reset.
- flush_i  input  1  synchronous clear of all buffered data; active-high.
- mac_data_frame_i  input  MAC_FRAME_WIDTH  frame from the DLL.
- mac_data_frame_valid_i  input  1  frame valid.
- mac_frame_last_i  input  1  frame is the final frame of a packet; qualified by valid.
- mac_data_frame_ready_o  output  1  FIFO can accept a frame.
- byte_o  output  8  serialized byte to the lane controller.
- byte_valid_o  output  1  byte_o valid.
- byte_ready_i  input  1  downstream accepts byte.
- byte_sop_o  output  1  first byte of a packet.
- byte_eop_o  output  1  last byte of a packet.
- fifo_level_o  output  $clog2(FIFO_DEPTH+1)  frames currently in the FIFO.

Behaviour:
- Reset (rst_i==0 at an edge): FIFO empty, byte_valid_o=0, byte_o=0, byte_sop_o=0, byte_eop_o=0, fifo_level_o=0, mac_data_frame_ready_o=1 from the following cycle, byte index=0, sop_pending=1. Reset mid-packet discards all data; no partial bytes are emitted.
- Push: a frame is written when valid && ready at an edge. mac_data_frame_ready_o = !full and depends on registered state only; there is no push-while-full, even with a simultaneous pop.
- Pop: the head frame leaves the FIFO at the edge where its last byte loads into the output register.
- Output register: loads when (!byte_valid_o || byte_ready_i) && FIFO non-empty. The loaded value is byte_o = head[8*idx +: 8], and idx increments mod BYTES_PER_FRAME.
- If the load condition is true and the FIFO is empty, byte_valid_o clears.
- byte_o, byte_sop_o and byte_eop_o hold stable while byte_valid_o && !byte_ready_i.
- Latency: a frame pushed into an idle block at edge k gives byte 0 valid after edge k+1.
- Throughput: 1 byte/cycle with byte_ready_i held high. Back-to-back frames produce no bubbles.
- byte_sop_o=1 on byte 0 when sop_pending=1. sop_pending clears on that load and sets again when an eop byte loads.
- byte_eop_o=1 on byte BYTES_PER_FRAME-1 of a frame stored with last=1.
- State machine: IDLE (byte_valid_o=0) and STREAM.
  - IDLE->STREAM on load.
  - STREAM->IDLE when the current byte is accepted and the FIFO is empty.
  - STREAM stays otherwise.
- flush_i at an edge: same effect as reset, except ready_o stays 1. flush_i has priority over a simultaneous push or pop.
- fifo_level_o updates in the cycle after a push or pop. A simultaneous push and pop leaves the level unchanged.

Optional Feature:
- MAC_SERIALIZER_PARTIAL_EN defined: adds input port mac_frame_nbytes_i, width $clog2(BYTES_PER_FRAME), qualified by valid && last. The value 0 means all bytes.
  - On a last frame, only nbytes bytes are emitted. eop is set on byte nbytes-1, then the frame pops.
  - The nbytes field is stored per FIFO entry.
- Not defined: the port is absent and every frame emits BYTES_PER_FRAME bytes.

Decomposition:
- Package pcie_phys_pkg holds:
  - BYTES_PER_FRAME derivation function.
  - pcie_byte_t (8-bit typedef).
  - serializer state enum {SER_IDLE, SER_STREAM}.
  - FIFO entry struct {data, last[, nbytes]}.
- Sub-module pcie_sync_fifo: generic synchronous FIFO with full, empty and level outputs, same reset convention. The serializer instantiates it with the entry struct width.

Test Plan:
- Reset/idle: hold rst_i=0 for 3 cycles, then release. Required: byte_valid_o=0, fifo_level_o=0, mac_data_frame_ready_o=1, byte_o=0.
- Single frame: push 32'hDDCCBBAA with last=1, byte_ready_i=1. Required: after 1 cycle of latency, bytes AA,BB,CC,DD on consecutive cycles; sop on AA, eop on DD; then byte_valid_o=0.
- Backpressure/full: hold byte_ready_i=0 and push frames 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C.
  - Required while stalled: ready_o falls after the 4th push, level=4, byte_o held at 0x00.
  - Then release byte_ready_i. Required: bytes 0x00..0x0F in order with no gaps, and ready_o returns the cycle after the first pop.
- Multi-packet: push frame A (last=0), B (last=1), C (last=1). Required: sop on A byte 0 and C byte 0, eop on B byte 3 and C byte 3, no sop on B.
- Flush mid-frame: push 2 frames, let 2 bytes drain, assert flush_i together with a push. Required: the next cycle has byte_valid_o=0, level=0, and the pushed frame is dropped; the next packet's first byte carries sop.
- Partial (MAC_SERIALIZER_PARTIAL_EN): push 32'h44332211 with last=1 and nbytes=3. Required: 11,22,33 with eop on 33, then byte_valid_o=0.

Source files
------------

// File: rtl/pcie_phys_pkg.sv
// pcie_phys_pkg: shared types for the PHY TX byte path.
// Optional feature macro: MAC_SERIALIZER_PARTIAL_EN.
package pcie_phys_pkg;

  function automatic int bytes_per_frame(input int width);
    return width / 8;
  endfunction

  localparam int MAC_FRAME_W = 32;
  localparam int FRAME_BYTES = bytes_per_frame(MAC_FRAME_W);
  localparam int NB_W =
    (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;

  typedef logic [7:0] pcie_byte_t;

  typedef enum logic {
    SER_IDLE,
    SER_STREAM
  } ser_state_t;

  typedef struct packed {
    logic [MAC_FRAME_W-1:0] data;
    logic                   last;
`ifdef MAC_SERIALIZER_PARTIAL_EN
    logic [NB_W-1:0]        nbytes;
`endif
  } mac_entry_t;

endpackage

// File: rtl/pcie_sync_fifo.sv
// pcie_sync_fifo: show-ahead synchronous FIFO with level.
// Synchronous active-low reset; flush clears like reset.
module pcie_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic             w_push;
  logic             w_pop;

  assign full_o    = (r_level == LW'(DEPTH));
  assign empty_o   = (r_level == '0);
  assign w_push    = wr_en_i && !full_o;
  assign w_pop     = rd_en_i && !empty_o;
  assign rd_data_o = r_mem[r_rptr];
  assign level_o   = r_level;

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= wr_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i || flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/mac_frame_serializer.sv
// mac_frame_serializer: MAC frames -> LSB-first byte stream.
// MAC_SERIALIZER_PARTIAL_EN adds a byte count on last frames.
module mac_frame_serializer
  import pcie_phys_pkg::*;
#(
  parameter  int MAC_FRAME_WIDTH = MAC_FRAME_W,
  parameter  int FIFO_DEPTH      = 4,
  localparam int BYTES_PER_FRAME =
    bytes_per_frame(MAC_FRAME_WIDTH),
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic [MAC_FRAME_WIDTH-1:0] mac_data_frame_i,
  input  logic                       mac_data_frame_valid_i,
  input  logic                       mac_frame_last_i,
`ifdef MAC_SERIALIZER_PARTIAL_EN
  input  logic [NB_W-1:0]            mac_frame_nbytes_i,
`endif
  output logic                       mac_data_frame_ready_o,
  output pcie_byte_t                 byte_o,
  output logic                       byte_valid_o,
  input  logic                       byte_ready_i,
  output logic                       byte_sop_o,
  output logic                       byte_eop_o,
  output logic [LVL_W-1:0]           fifo_level_o
);

  localparam int ENTRY_W = $bits(mac_entry_t);
  localparam logic [NB_W-1:0] IDX_MAX =
    NB_W'(BYTES_PER_FRAME - 1);

  ser_state_t         r_state;
  ser_state_t         w_state_nxt;
  mac_entry_t         w_wr_entry;
  mac_entry_t         w_head;
  logic [ENTRY_W-1:0] w_head_raw;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_valid;
  logic               w_adv;
  logic               w_load;
  logic               w_final;
  logic               w_pop;
  logic [NB_W-1:0]    w_last_idx;
  logic [NB_W-1:0]    r_idx;
  pcie_byte_t         r_byte;
  logic               r_sop;
  logic               r_eop;
  logic               r_sop_pend;

  always_comb begin
    w_wr_entry      = '0;
    w_wr_entry.data = mac_data_frame_i;
    w_wr_entry.last = mac_frame_last_i;
`ifdef MAC_SERIALIZER_PARTIAL_EN
    w_wr_entry.nbytes = mac_frame_nbytes_i;
`endif
  end

  assign w_push = mac_data_frame_valid_i && !w_full;

  pcie_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .flush_i   (flush_i),
    .wr_en_i   (w_push),
    .wr_data_i (w_wr_entry),
    .rd_en_i   (w_pop),
    .rd_data_o (w_head_raw),
    .full_o    (w_full),
    .empty_o   (w_empty),
    .level_o   (fifo_level_o)
  );

  assign w_head = mac_entry_t'(w_head_raw);

  // A count of zero on a last frame still means a full frame.
  always_comb begin
    w_last_idx = IDX_MAX;
`ifdef MAC_SERIALIZER_PARTIAL_EN
    if (w_head.last && w_head.nbytes != '0)
      w_last_idx = w_head.nbytes - 1'b1;
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    w_valid     = (r_state == SER_STREAM);
    w_adv       = !w_valid || byte_ready_i;
    w_load      = w_adv && !w_empty;
    w_final     = (r_idx == w_last_idx);
    w_pop       = w_load && w_final;
    unique case (r_state)
      SER_IDLE:
        if (w_load) w_state_nxt = SER_STREAM;
      SER_STREAM:
        if (byte_ready_i && w_empty)
          w_state_nxt = SER_IDLE;
      default: w_state_nxt = SER_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i || flush_i) r_state <= SER_IDLE;
    else                   r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i || flush_i) begin
      r_byte     <= '0;
      r_sop      <= 1'b0;
      r_eop      <= 1'b0;
      r_idx      <= '0;
      r_sop_pend <= 1'b1;
    end else if (w_load) begin
      r_byte <= w_head.data[{r_idx, 3'b000} +: 8];
      r_sop  <= r_sop_pend && (r_idx == '0);
      r_eop  <= w_final && w_head.last;
      r_idx  <= w_final ? '0 : r_idx + 1'b1;
      if (w_final && w_head.last)
        r_sop_pend <= 1'b1;
      else if (r_idx == '0)
        r_sop_pend <= 1'b0;
    end
  end

  assign mac_data_frame_ready_o = !w_full;
  assign byte_o                 = r_byte;
  assign byte_valid_o           = w_valid;
  assign byte_sop_o             = r_sop;
  assign byte_eop_o             = r_eop;

endmodule

// File: tb/tb_mac_frame_serializer.sv
// tb_mac_frame_serializer: scoreboard bench for the serializer.
// Frame-level model expands each accepted frame into bytes.
module tb_mac_frame_serializer;

`ifdef MAC_SERIALIZER_PARTIAL_EN
  localparam bit PARTIAL = 1'b1;
`else
  localparam bit PARTIAL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] data = '0;
  logic        valid = 1'b0;
  logic        last = 1'b0;
`ifdef MAC_SERIALIZER_PARTIAL_EN
  logic [1:0]  nbytes = '0;
`endif
  logic        ready;
  logic [7:0]  byte_o;
  logic        byte_valid;
  logic        byte_ready;
  logic        sop;
  logic        eop;
  logic [2:0]  level;

  logic rdy_rand = 1'b0;
  logic rdy_fixed = 1'b1;
  logic rdy_rnd_val = 1'b1;
  assign byte_ready = rdy_rand ? rdy_rnd_val : rdy_fixed;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] b;
    logic       s;
    logic       e;
  } exp_t;

  exp_t q[$];
  bit   model_sop = 1'b1;
  exp_t held;
  bit   hold_prev = 1'b0;

  mac_frame_serializer dut (
    .clk_i                  (clk),
    .rst_i                  (rst_i),
    .flush_i                (flush_i),
    .mac_data_frame_i       (data),
    .mac_data_frame_valid_i (valid),
    .mac_frame_last_i       (last),
`ifdef MAC_SERIALIZER_PARTIAL_EN
    .mac_frame_nbytes_i     (nbytes),
`endif
    .mac_data_frame_ready_o (ready),
    .byte_o                 (byte_o),
    .byte_valid_o           (byte_valid),
    .byte_ready_i           (byte_ready),
    .byte_sop_o             (sop),
    .byte_eop_o             (eop),
    .fifo_level_o           (level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rdy_rnd_val = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, req);
    end
  endtask

  // Each accepted frame becomes n expected bytes.
  function automatic void model_add(input logic [31:0] d,
                                    input logic l,
                                    input int nb);
    int n;
    exp_t e;
    n = 4;
    if (PARTIAL && l && nb != 0) n = nb;
    for (int i = 0; i < n; i++) begin
      e.b = d[8*i +: 8];
      e.s = model_sop && (i == 0);
      e.e = l && (i == n - 1);
      q.push_back(e);
    end
    model_sop = l;
  endfunction

  always @(negedge clk) begin
    if (rst_i && byte_valid) begin
      if (hold_prev) begin
        checks++;
        if (byte_o !== held.b || sop !== held.s ||
            eop !== held.e) begin
          errors++;
          $display("FAIL hold actual=%h/%b/%b required=%h/%b/%b",
                   byte_o, sop, eop, held.b, held.s, held.e);
        end
      end
      if (byte_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte actual=%h required=none",
                   byte_o);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (byte_o !== e.b || sop !== e.s || eop !== e.e) begin
            errors++;
            $display("FAIL byte actual=%h/%b/%b required=%h/%b/%b",
                     byte_o, sop, eop, e.b, e.s, e.e);
          end
        end
      end
      hold_prev = !byte_ready;
      held.b = byte_o;
      held.s = sop;
      held.e = eop;
    end else begin
      hold_prev = 1'b0;
    end
  end

  // Called at posedge+1; returns at posedge+1 after acceptance.
  task automatic push(input logic [31:0] d,
                      input logic l,
                      input int nb);
    bit done;
    bit acc;
    done = 1'b0;
    valid = 1'b1;
    data = d;
    last = l;
`ifdef MAC_SERIALIZER_PARTIAL_EN
    nbytes = nb[1:0];
`endif
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      acc = ready;
      @(posedge clk);
      #1;
      if (acc) begin
        model_add(d, l, nb);
        done = 1'b1;
      end
    end
    valid = 1'b0;
    if (!done) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(input string name);
    for (int t = 0; t < 400 && q.size() != 0; t++)
      @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk({name, "_remaining"}, q.size(), 0);
    chk({name, "_idle"}, {31'd0, byte_valid}, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(negedge clk);
    chk("rst_valid", {31'd0, byte_valid}, 0);
    chk("rst_level", {29'd0, level}, 0);
    chk("rst_ready", {31'd0, ready}, 1);
    chk("rst_byte", {24'd0, byte_o}, 0);
    @(posedge clk);
    #1;

    push(32'hDDCCBBAA, 1'b1, 0);
    @(negedge clk);
    chk("lat_idle", {31'd0, byte_valid}, 0);
    @(negedge clk);
    chk("lat_valid", {31'd0, byte_valid}, 1);
    chk("lat_byte", {24'd0, byte_o}, 32'hAA);
    chk("lat_sop", {31'd0, sop}, 1);
    drain("single");

    rdy_fixed = 1'b0;
    push(32'h03020100, 1'b0, 0);
    push(32'h07060504, 1'b0, 0);
    push(32'h0B0A0908, 1'b0, 0);
    push(32'h0F0E0D0C, 1'b1, 0);
    @(negedge clk);
    chk("full_ready", {31'd0, ready}, 0);
    chk("full_level", {29'd0, level}, 4);
    chk("full_byte", {24'd0, byte_o}, 0);
    chk("full_valid", {31'd0, byte_valid}, 1);
    @(posedge clk);
    #1;
    rdy_fixed = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("nogap_valid", {31'd0, byte_valid}, 1);
      if (i < 4)
        chk("ready_return", {31'd0, ready}, {31'd0, i >= 3});
    end
    drain("stall");

    push(32'h13121110, 1'b0, 0);
    push(32'h17161514, 1'b1, 0);
    push(32'h1B1A1918, 1'b1, 0);
    drain("multi");

    push(32'h23222120, 1'b0, 0);
    push(32'h27262524, 1'b1, 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    flush_i = 1'b1;
    valid = 1'b1;
    data = 32'hEEEEEEEE;
    last = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    valid = 1'b0;
    q.delete();
    model_sop = 1'b1;
    @(negedge clk);
    chk("flush_valid", {31'd0, byte_valid}, 0);
    chk("flush_level", {29'd0, level}, 0);
    chk("flush_ready", {31'd0, ready}, 1);
    @(posedge clk);
    #1;
    push(32'h33323130, 1'b1, 0);
    drain("post_flush");

`ifdef MAC_SERIALIZER_PARTIAL_EN
    push(32'h44332211, 1'b1, 3);
    drain("partial");
`endif

    rdy_rand = 1'b1;
    for (int f = 0; f < 60; f++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk);
        #1;
      end
      push($urandom, ($urandom_range(0, 9) < 3),
           $urandom_range(0, 3));
    end
    rdy_rand = 1'b0;
    rdy_fixed = 1'b1;
    drain("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
